// File: rtl/token_precision_scorer_if.sv
// Row-stream and result bundle for the token precision scorer.
interface token_precision_scorer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8
);
  logic                    start;
  logic                    row_valid;
  logic                    row_ready;
  logic [DATA_WIDTH*L-1:0] row_data;
  logic [3:0]              token_precision [L-1:0];
  logic                    done;
  logic                    out_valid;
  logic                    busy;

  modport master (
    output start, row_valid, row_data,
    input  row_ready, token_precision,
    input  done, out_valid, busy
  );

  modport slave (
    input  start, row_valid, row_data,
    output row_ready, token_precision,
    output done, out_valid, busy
  );
endinterface

// File: rtl/token_precision_scorer.sv
// Column-max attention scorer assigning per-token INT4/INT8/FP16 codes.
// Optional TPS_STATS_EN adds per-code token counts.
module token_precision_scorer #(
  parameter int          DATA_WIDTH = 16,
  parameter int          L          = 8,
  parameter logic [15:0] THR_HI     = 16'h3000,
  parameter logic [15:0] THR_LO     = 16'h2000
) (
  input logic clk,
  input logic rst,
  token_precision_scorer_if.slave bus
`ifdef TPS_STATS_EN
  ,
  output logic [$clog2(L+1)-1:0] cnt_int4,
  output logic [$clog2(L+1)-1:0] cnt_int8,
  output logic [$clog2(L+1)-1:0] cnt_fp16
`endif
);

  localparam int CW = $clog2(L);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] row_cnt;
  logic [15:0]   colmax [L-1:0];
  logic [15:0]   mag    [L-1:0];
  logic [3:0]    code   [L-1:0];
  logic [3:0]    tp     [L-1:0];
  logic          done_q;
  logic          out_valid_q;
  logic          accept;
  logic          last_row;

  // Negatives score as zero; NaN/Inf saturate to +Inf.
  function automatic logic [15:0] fp_mag(input logic [15:0] x);
    if (x[15])
      return 16'h0000;
    else if (x[14:10] == 5'h1F)
      return 16'h7C00;
    else
      return x;
  endfunction

  assign accept   = (state == ACCUM) && bus.row_valid;
  assign last_row = (row_cnt == CW'(L-1));

  always_comb begin
    for (int c = 0; c < L; c++) begin
      mag[c] = fp_mag(bus.row_data[c*DATA_WIDTH +: 16]);
      if (colmax[c] >= THR_HI)
        code[c] = 4'd2;
      else if (colmax[c] >= THR_LO)
        code[c] = 4'd1;
      else
        code[c] = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (bus.start) state_n = ACCUM;
      ACCUM:  if (accept && last_row) state_n = DECIDE;
      DECIDE: state_n = DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < L; c++) begin
        colmax[c] <= 16'h0000;
        tp[c]     <= 4'd2;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            row_cnt     <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < L; c++)
              colmax[c] <= 16'h0000;
          end
        end
        ACCUM: begin
          if (accept) begin
            for (int c = 0; c < L; c++)
              if (mag[c] > colmax[c])
                colmax[c] <= mag[c];
            if (!last_row)
              row_cnt <= row_cnt + CW'(1);
          end
        end
        DECIDE: begin
          done_q      <= 1'b1;
          out_valid_q <= 1'b1;
          for (int c = 0; c < L; c++)
            tp[c] <= code[c];
        end
        DONE: done_q <= 1'b0;
        default: done_q <= 1'b0;
      endcase
    end
  end

`ifdef TPS_STATS_EN
  localparam int SW = $clog2(L+1);

  logic [SW-1:0] n0, n1, n2;

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    for (int c = 0; c < L; c++) begin
      if (code[c] == 4'd0)
        n0 = n0 + SW'(1);
      else if (code[c] == 4'd1)
        n1 = n1 + SW'(1);
      else
        n2 = n2 + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_int4 <= '0;
      cnt_int8 <= '0;
      cnt_fp16 <= '0;
    end else if (state == DECIDE) begin
      cnt_int4 <= n0;
      cnt_int8 <= n1;
      cnt_fp16 <= n2;
    end
  end
`endif

  assign bus.row_ready       = (state == ACCUM);
  assign bus.busy            = (state != IDLE);
  assign bus.done            = done_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.token_precision = tp;

endmodule

// File: tb/tb_token_precision_scorer.sv
// Directed bench for token_precision_scorer (L=8, default thresholds).
module tb_token_precision_scorer;

  localparam int L = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m      [L][L];
  logic [3:0]  exp_tp [L];
  logic [3:0]  prev_tp[L];

`ifdef TPS_STATS_EN
  logic [3:0] cnt_int4, cnt_int8, cnt_fp16;
`endif

  token_precision_scorer_if #(.DATA_WIDTH(16), .L(L)) bus ();

  token_precision_scorer #(.DATA_WIDTH(16), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef TPS_STATS_EN
    ,
    .cnt_int4 (cnt_int4),
    .cnt_int8 (cnt_int8),
    .cnt_fp16 (cnt_fp16)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int r);
    for (int c = 0; c < L; c++)
      bus.row_data[c*16 +: 16] = m[r][c];
  endtask

  task automatic fill(input logic [15:0] v);
    for (int r = 0; r < L; r++)
      for (int c = 0; c < L; c++)
        m[r][c] = v;
  endtask

  task automatic test_reset();
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.busy !== 1'b0 || bus.row_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: done=%b ov=%b busy=%b rdy=%b, want 0000",
               bus.done, bus.out_valid, bus.busy, bus.row_ready);
    end
    for (int c = 0; c < L; c++) begin
      checks++;
      if (bus.token_precision[c] !== 4'd2) begin
        errors++;
        $display("FAIL reset_tp[%0d]: got %0d want 2", c,
                 bus.token_precision[c]);
      end
      prev_tp[c] = 4'd2;
    end
`ifdef TPS_STATS_EN
    checks++;
    if (cnt_int4 !== 0 || cnt_int8 !== 0 || cnt_fp16 !== 0) begin
      errors++;
      $display("FAIL reset_cnt: %0d %0d %0d want 0 0 0",
               cnt_int4, cnt_int8, cnt_fp16);
    end
`endif
  endtask

  // Scores matrix m; toggle inserts bubbles and holds start high.
  task automatic run_matrix(input bit toggle, input string name);
    int acc = 0;
    int cyc = 0;
    bit hs;
    int n0 = 0, n1 = 0, n2 = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: ov=%b busy=%b want 0 1",
               name, bus.out_valid, bus.busy);
    end
    for (int c = 0; c < L; c++) begin
      checks++;
      if (bus.token_precision[c] !== prev_tp[c]) begin
        errors++;
        $display("FAIL %s_hold_old[%0d]: got %0d want %0d", name, c,
                 bus.token_precision[c], prev_tp[c]);
      end
    end
    while (acc < L && cyc < 200) begin
      if (toggle && cyc[0]) begin
        bus.row_valid = 1'b0;
        bus.start     = 1'b1;
      end else begin
        bus.row_valid = 1'b1;
        bus.start     = toggle;
        load_row(acc);
      end
      hs = bus.row_valid && bus.row_ready;
      tick();
      cyc++;
      if (hs) acc++;
    end
    bus.row_valid = 1'b0;
    bus.start     = 1'b0;
    checks++;
    if (acc != L) begin
      errors++;
      $display("FAIL %s_accepts: got %0d want %0d", name, acc, L);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.row_ready !== 1'b0 ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_decide: done=%b rdy=%b busy=%b want 0 0 1",
               name, bus.done, bus.row_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done=%b ov=%b want 1 1",
               name, bus.done, bus.out_valid);
    end
    for (int c = 0; c < L; c++) begin
      checks++;
      if (bus.token_precision[c] !== exp_tp[c]) begin
        errors++;
        $display("FAIL %s_tp[%0d]: got %0d want %0d", name, c,
                 bus.token_precision[c], exp_tp[c]);
      end
      if (exp_tp[c] == 0) n0++;
      else if (exp_tp[c] == 1) n1++;
      else n2++;
    end
`ifdef TPS_STATS_EN
    checks++;
    if (cnt_int4 !== 4'(n0) || cnt_int8 !== 4'(n1) ||
        cnt_fp16 !== 4'(n2)) begin
      errors++;
      $display("FAIL %s_cnt: %0d %0d %0d want %0d %0d %0d", name,
               cnt_int4, cnt_int8, cnt_fp16, n0, n1, n2);
    end
`endif
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b ov=%b want 0 0 1",
               name, bus.done, bus.busy, bus.out_valid);
    end
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.done !== 1'b0 ||
        bus.token_precision[L-1] !== exp_tp[L-1]) begin
      errors++;
      $display("FAIL %s_hold: ov=%b done=%b tp7=%0d want 1 0 %0d",
               name, bus.out_valid, bus.done,
               bus.token_precision[L-1], exp_tp[L-1]);
    end
    for (int c = 0; c < L; c++)
      prev_tp[c] = exp_tp[c];
  endtask

  task automatic test_back_to_back();
    fill(16'h3C00);
    for (int c = 0; c < L; c++) exp_tp[c] = 4'd2;
    run_matrix(1'b0, "b2b");
  endtask

  task automatic test_thresholds();
    fill(16'h0000);
    for (int r = 0; r < L; r++) begin
      m[r][0] = 16'h1000;
      m[r][1] = 16'h0800;
      m[r][2] = 16'h2C00;
    end
    m[0][0] = 16'hFC00;
    m[3][0] = 16'h2400;
    m[6][1] = 16'h1000;
    m[7][2] = 16'h3000;
    for (int c = 0; c < L; c++) exp_tp[c] = 4'd0;
    exp_tp[0] = 4'd1;
    exp_tp[2] = 4'd2;
    run_matrix(1'b0, "thr");
  endtask

  task automatic test_sign_nan();
    fill(16'h0000);
    for (int r = 0; r < L; r++) begin
      m[r][3] = r[0] ? 16'h8000 : 16'hBC00;
      m[r][6] = 16'h1FFF;
    end
    m[0][0] = 16'h3000;
    m[2][4] = 16'h7E00;
    m[1][5] = 16'h7C00;
    m[4][7] = 16'h2000;
    exp_tp = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd2, 4'd2, 4'd0, 4'd1};
    run_matrix(1'b0, "sign");
  endtask

  task automatic test_bubbles();
    fill(16'h3C00);
    for (int c = 0; c < L; c++) exp_tp[c] = 4'd2;
    run_matrix(1'b1, "bubble");
  endtask

  task automatic test_mid_reset();
    fill(16'h5000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.row_valid = 1'b1;
      load_row(r);
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.row_ready !== 1'b0 ||
        bus.done !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.token_precision[1] !== 4'd2) begin
      errors++;
      $display("FAIL midrst: busy=%b rdy=%b done=%b ov=%b tp1=%0d",
               bus.busy, bus.row_ready, bus.done, bus.out_valid,
               bus.token_precision[1]);
    end
    tick();
    rst = 1'b0;
    bus.row_valid = 1'b0;
    for (int c = 0; c < L; c++) prev_tp[c] = 4'd2;
    fill(16'h0000);
    for (int r = 0; r < L; r++) m[r][1] = 16'h2800;
    for (int c = 0; c < L; c++) exp_tp[c] = 4'd0;
    exp_tp[1] = 4'd1;
    run_matrix(1'b0, "rerun");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_thresholds();
    test_sign_nan();
    test_bubbles();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
